// File: rtl/cd2ab_dec_pkg.sv
// Shared DQPSK definitions: dibit/phase mapping, index conversions and decoder states.
// Used by both the transmit-side encoder and the receive-side decoder.
package cd2ab_dec_pkg;

  localparam logic [1:0] PH_0   = 2'b00;
  localparam logic [1:0] PH_90  = 2'b10;
  localparam logic [1:0] PH_180 = 2'b11;
  localparam logic [1:0] PH_270 = 2'b01;

  localparam logic [1:0] REF_INIT = PH_0;

  typedef enum logic {
    StRef,
    StRun
  } state_e;

  // Dibit to phase index (quarter turns).
  function automatic logic [1:0] idx(input logic [1:0] dibit);
    case (dibit)
      PH_0:    idx = 2'd0;
      PH_90:   idx = 2'd1;
      PH_180:  idx = 2'd2;
      default: idx = 2'd3;
    endcase
  endfunction

  // Phase index (quarter turns) to dibit.
  function automatic logic [1:0] code(input logic [1:0] phase);
    case (phase)
      2'd0:    code = PH_0;
      2'd1:    code = PH_90;
      2'd2:    code = PH_180;
      default: code = PH_270;
    endcase
  endfunction

endpackage

// File: rtl/cd2ab_stat.sv
// Saturating delivery counters for the DQPSK decoder; cleared only by the
// synchronous active-low reset.
module cd2ab_stat #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_xfer,
  input  logic             i_zero,
  output logic [CNT_W-1:0] o_sym_cnt,
  output logic [CNT_W-1:0] o_hold_cnt
);

  logic [CNT_W-1:0] r_sym;
  logic [CNT_W-1:0] r_hold;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sym  <= '0;
      r_hold <= '0;
    end else if (i_xfer) begin
      if (r_sym != '1) begin
        r_sym <= r_sym + 1'b1;
      end
      if (i_zero && (r_hold != '1)) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign o_sym_cnt  = r_sym;
  assign o_hold_cnt = r_hold;

endmodule

// File: rtl/cd2ab_dec.sv
// DQPSK relative-to-absolute dibit decoder with valid/ready on both sides.
// Optional statistics counters are built when CD2AB_STAT_EN is defined.
module cd2ab_dec
  import cd2ab_dec_pkg::*;
#(
  parameter bit          SKIP_FIRST = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restart,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic [1:0]       i_cd,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic [1:0]       o_ab
`ifdef CD2AB_STAT_EN
  ,
  output logic [CNT_W-1:0] o_sym_cnt,
  output logic [CNT_W-1:0] o_hold_cnt
`endif
);

  localparam state_e InitState = SKIP_FIRST ? StRef : StRun;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be nonzero");
  end

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_ref;
  logic [1:0] w_ref_d;
  logic       r_valid;
  logic       w_valid_d;
  logic [1:0] r_ab;
  logic [1:0] w_ab_d;

  logic       w_accept;
  logic       w_xfer;
  logic [1:0] w_delta;

  assign o_din_ready = ~i_restart & (~r_valid | i_dout_ready);
  assign w_accept    = i_din_valid & o_din_ready;
  assign w_xfer      = r_valid & i_dout_ready;
  assign w_delta     = idx(i_cd) - idx(r_ref);

  always_comb begin
    w_state_d = r_state;
    w_ref_d   = r_ref;
    w_valid_d = r_valid;
    w_ab_d    = r_ab;
    if (i_restart) begin
      w_state_d = InitState;
      w_ref_d   = REF_INIT;
      w_valid_d = 1'b0;
    end else begin
      if (w_xfer) begin
        w_valid_d = 1'b0;
      end
      if (w_accept) begin
        w_ref_d = i_cd;
        unique case (r_state)
          StRef: w_state_d = StRun;
          StRun: begin
            w_valid_d = 1'b1;
            w_ab_d    = code(w_delta);
          end
          default: w_state_d = InitState;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= InitState;
      r_ref   <= REF_INIT;
      r_valid <= 1'b0;
      r_ab    <= 2'b00;
    end else begin
      r_state <= w_state_d;
      r_ref   <= w_ref_d;
      r_valid <= w_valid_d;
      r_ab    <= w_ab_d;
    end
  end

  assign o_dout_valid = r_valid;
  assign o_ab         = r_ab;

`ifdef CD2AB_STAT_EN
  // A transfer coinciding with restart is dropped, so it is not counted.
  logic w_deliver;
  assign w_deliver = w_xfer & ~i_restart;

  cd2ab_stat #(
    .CNT_W(CNT_W)
  ) u_stat (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_xfer    (w_deliver),
    .i_zero    (r_ab == 2'b00),
    .o_sym_cnt (o_sym_cnt),
    .o_hold_cnt(o_hold_cnt)
  );
`endif

endmodule

// File: tb/tb_cd2ab_dec.sv
// Scoreboard bench for cd2ab_dec: two instances (SKIP_FIRST=0 and 1) share stimulus;
// a phase-angle reference model predicts, a separate monitor pops and compares deliveries.
module tb_cd2ab_dec;

  localparam int unsigned CW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       restart = 1'b0;
  logic       din_valid = 1'b0;
  logic [1:0] cd = 2'b00;
  logic       dout_ready = 1'b1;

  logic [1:0] rdy;
  logic [1:0] vld;
  logic [1:0] ab0, ab1;
  logic [CW-1:0] sym0, sym1, hold0, hold1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cd2ab_dec #(.SKIP_FIRST(1'b0), .CNT_W(CW)) u_dut0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_restart   (restart),
    .i_din_valid (din_valid),
    .o_din_ready (rdy[0]),
    .i_cd        (cd),
    .o_dout_valid(vld[0]),
    .i_dout_ready(dout_ready),
    .o_ab        (ab0)
`ifdef CD2AB_STAT_EN
    ,
    .o_sym_cnt   (sym0),
    .o_hold_cnt  (hold0)
`endif
  );

  cd2ab_dec #(.SKIP_FIRST(1'b1), .CNT_W(CW)) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_restart   (restart),
    .i_din_valid (din_valid),
    .o_din_ready (rdy[1]),
    .i_cd        (cd),
    .o_dout_valid(vld[1]),
    .i_dout_ready(dout_ready),
    .o_ab        (ab1)
`ifdef CD2AB_STAT_EN
    ,
    .o_sym_cnt   (sym1),
    .o_hold_cnt  (hold1)
`endif
  );

`ifndef CD2AB_STAT_EN
  assign sym0 = '0;
  assign sym1 = '0;
  assign hold0 = '0;
  assign hold1 = '0;
`endif

  task automatic check(input string name, input int k, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d want %0d at %0t", name, k, got, want, $time);
    end
  endtask

  // Reference model works in degrees, independent of any index arithmetic.
  function automatic int deg(input logic [1:0] d);
    case (d)
      2'b00:   deg = 0;
      2'b10:   deg = 90;
      2'b11:   deg = 180;
      default: deg = 270;
    endcase
  endfunction

  function automatic logic [1:0] from_deg(input int a);
    case (a)
      0:       from_deg = 2'b00;
      90:      from_deg = 2'b10;
      180:     from_deg = 2'b11;
      default: from_deg = 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] decode(input logic [1:0] c, input logic [1:0] r);
    decode = from_deg((deg(c) - deg(r) + 360) % 360);
  endfunction

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  bit         m_valid[2] = '{1'b0, 1'b0};
  bit         m_run[2]   = '{1'b1, 1'b0};
  logic [1:0] m_ref[2]   = '{2'b00, 2'b00};
  logic [1:0] m_ab[2]    = '{2'b00, 2'b00};
  int         m_sym[2]   = '{0, 0};
  int         m_hold[2]  = '{0, 0};

  // Predictor: checks handshake/state, then advances the model across the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit exp_rdy;
      exp_rdy = !restart && (!m_valid[k] || dout_ready);
      check("din_ready", k, int'(rdy[k]), int'(exp_rdy));
      check("dout_valid", k, int'(vld[k]), int'(m_valid[k]));
      check("ab_hold", k, int'((k == 0) ? ab0 : ab1), int'(m_ab[k]));
      if (!rst || restart) begin
        m_valid[k] = 1'b0;
        m_ref[k]   = 2'b00;
        m_run[k]   = (k == 0);
        if (k == 0) q0.delete(); else q1.delete();
        if (!rst) m_ab[k] = 2'b00;
      end else begin
        if (m_valid[k] && dout_ready) m_valid[k] = 1'b0;
        if (din_valid && exp_rdy) begin
          if (m_run[k]) begin
            m_ab[k]    = decode(cd, m_ref[k]);
            m_valid[k] = 1'b1;
            if (k == 0) q0.push_back(m_ab[k]); else q1.push_back(m_ab[k]);
          end else begin
            m_run[k] = 1'b1;
          end
          m_ref[k] = cd;
        end
      end
    end
  end

  // Monitor: pops an expected symbol for every delivery the DUT makes.
  always @(negedge clk) begin
`ifdef CD2AB_STAT_EN
    check("sym_cnt", 0, int'(sym0), m_sym[0]);
    check("hold_cnt", 0, int'(hold0), m_hold[0]);
    check("sym_cnt", 1, int'(sym1), m_sym[1]);
    check("hold_cnt", 1, int'(hold1), m_hold[1]);
`endif
    if (!rst) begin
      m_sym[0] = 0;  m_sym[1] = 0;
      m_hold[0] = 0; m_hold[1] = 0;
    end else if (!restart) begin
      for (int k = 0; k < 2; k++) begin
        if (vld[k] && dout_ready) begin
          logic [1:0] exp_ab;
          logic [1:0] got_ab;
          got_ab = (k == 0) ? ab0 : ab1;
          if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL deliver dut%0d: got ab %b want no delivery at %0t", k, got_ab, $time);
          end else begin
            exp_ab = (k == 0) ? q0.pop_front() : q1.pop_front();
            check("deliver_ab", k, int'(got_ab), int'(exp_ab));
            m_sym[k]++;
            if (exp_ab == 2'b00) m_hold[k]++;
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit rs, input bit dv, input logic [1:0] c,
                      input bit dr);
    @(posedge clk);
    #1;
    rst        = r;
    restart    = rs;
    din_valid  = dv;
    cd         = c;
    dout_ready = dr;
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    // Round trip
    step(1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    // Backpressure for three cycles mid-stream
    step(1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    // Wrap cases after restart
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    // Restart with pending output and an offered symbol
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    // Reset mid-stream
    step(1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) != 0), ($urandom_range(29) == 0), ($urandom_range(3) != 0),
           2'($urandom_range(3)), ($urandom_range(2) != 0));
    end
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cd2ab_dec.md
# cd2ab_dec

Receive-side DQPSK differential decoder: converts the relative (differentially encoded) dibit stream recovered by the demodulator back into absolute dibits. It is the exact inverse of the transmit-side absolute-to-relative encoder and shares its phase/dibit mapping and its reset reference of 2'b00. It sits between the symbol decision stage and the parallel-to-serial output stage, with valid/ready flow control on both sides.

## Interface
- SKIP_FIRST, 0: 0 = first symbol after reset/restart is decoded against reference 2'b00; 1 = first symbol only loads the reference, no output
- CNT_W, 16: width of the statistics counters (only used with the statistics feature)
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-low
- restart  in  1  resynchronise: reload reference and flush output
- din_valid  in  1  cd carries a symbol
- din_ready  out  1  decoder accepts a symbol this cycle
- cd  in  2  relative dibit
- dout_valid  out  1  ab carries a decoded symbol
- dout_ready  in  1  downstream accepts ab this cycle
- ab  out  2  absolute dibit
- sym_cnt  out  CNT_W  decoded symbols delivered (statistics builds only)
- hold_cnt  out  CNT_W  delivered symbols with ab==2'b00 (statistics builds only)

## Operation
- Phase index mapping is shared with the encoder: 2'b00=0, 2'b10=1, 2'b11=2, 2'b01=3. The same mapping applies to phase steps: ab 00=0°, 10=+90°, 11=+180°, 01=+270°.
- Decode rule: ab = code((idx(cd) − idx(ref)) mod 4), computed on 2-bit unsigned arithmetic with natural wrap. After each accepted symbol, ref <= cd.
- State machine:
  - REF: entered on reset or restart when SKIP_FIRST=1. An accepted symbol loads ref, produces no output, then moves to RUN.
  - RUN: entered on reset or restart when SKIP_FIRST=0, and from REF. Every accepted symbol is decoded and placed in the output register.
- Handshake:
  - Input accept = din_valid & din_ready.
  - Output transfer = dout_valid & dout_ready.
  - din_ready = !restart & (!dout_valid | dout_ready).
- Output register: loaded on accept in RUN. dout_valid clears on a transfer with no new load. ab holds stable while dout_valid & !dout_ready.
- restart: takes priority over all other events in the same cycle. Its effects:
  - ref <= 2'b00
  - dout_valid <= 0, and any pending output is dropped
  - state <= REF or RUN according to SKIP_FIRST
  - the input in that cycle is not accepted, because din_ready is 0
- Reset (rst low at a clock edge) has the same effect as restart and also clears ab to 2'b00.

## Timing
- Reset values: dout_valid=0, ab=2'b00, din_ready=1 once rst is high, sym_cnt=0, hold_cnt=0, ref=2'b00.
- Latency: one clock from input accept to dout_valid high.
- Throughput: one symbol per clock while dout_ready is held high.
- Backpressure: with dout_ready low and dout_valid high, din_ready is low in the same cycle (combinational).
- Simultaneous output transfer and input accept in RUN: the output register reloads and dout_valid stays 1.
- restart or reset mid-stream: the next accepted symbol is decoded against 2'b00 (SKIP_FIRST=0), or is swallowed as the reference (SKIP_FIRST=1).

## Configuration
- CD2AB_STAT_EN defined:
  - sym_cnt increments on every output transfer.
  - hold_cnt increments on every output transfer with ab==2'b00.
  - Both counters saturate at all-ones and are cleared by reset only, not by restart.
- CD2AB_STAT_EN undefined: sym_cnt and hold_cnt are absent from the port list and no counter logic is built.

## Structure
- The shared DQPSK package holds:
  - the phase-index constants PH_0/PH_90/PH_180/PH_270 (2'b00/2'b10/2'b11/2'b01)
  - the idx()/code() conversion functions
  - the state enum {REF, RUN}
  - the reset reference 2'b00
- The encoder and decoder both use this package.
- One sub-module: cd2ab_stat, containing the two saturating counters, instantiated under CD2AB_STAT_EN.

## Test plan
- Round trip, SKIP_FIRST=0, dout_ready=1: cd 10,11,00,01,01 on consecutive cycles -> ab 10,10,11,01,00, each one cycle after its input; sym_cnt=5 and hold_cnt=1 with stats enabled.
- Backpressure: dout_ready low for 3 cycles during the stream -> din_ready low for those cycles, ab frozen, no symbol lost or duplicated.
- Wrap: cd 01 then 00 -> second ab = code((0−3) mod 4)=10; cd 00 then 01 -> ab=01.
- SKIP_FIRST=1: cd 11,11,10 -> outputs 00,01 only; first symbol produces no dout_valid.
- restart with dout_valid=1 and din_valid=1 in the same cycle -> dout_valid 0 next cycle, input not accepted; following cd 10 decodes to ab 10.
- rst low mid-stream for one cycle -> all outputs at reset values next cycle; counters 0.
